// File: rtl/game_pkg.sv
// Shared types and sizes for the sprite layers and the palette path.
package game_pkg;

  localparam int unsigned COLOR_W       = 8;
  localparam int unsigned PAL_DEPTH     = 256;
  localparam int unsigned PAL_AW        = $clog2(PAL_DEPTH);
  localparam int unsigned RGB_W         = 24;
  localparam int unsigned LAYER_LATENCY = 1;

  typedef logic [COLOR_W-1:0] color_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Layer priority: fireboy over icegirl over background; background is never see-through.
  function automatic color_idx_t pick_layer(
    input logic       f,
    input color_idx_t fd,
    input logic       i,
    input color_idx_t id,
    input color_idx_t bg,
    input color_idx_t transp
  );
    color_idx_t idx;
    idx = bg;
    if (f && (fd != transp)) begin
      idx = fd;
    end else if (i && (id != transp)) begin
      idx = id;
    end
    return idx;
  endfunction

endpackage

// File: rtl/palette_ram.sv
// 256x24 colour palette: one write port, one registered read port returning old data on collision.
module palette_ram
  import game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_we,
  input  color_idx_t i_waddr,
  input  rgb_t       i_wdata,
  input  color_idx_t i_raddr,
  output rgb_t       o_rdata
);

  rgb_t r_mem [PAL_DEPTH];

  // Non-blocking write and read on the same edge yield the pre-write word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sprite_compositor.sv
// Aligns sprite flags with late ROM indices, resolves layer priority and drives
// palette-mapped RGB plus delayed syncs to the VGA DAC (3 edges of latency).
module sprite_compositor
  import game_pkg::*;
#(
  parameter color_idx_t  TRANSPARENT_IDX = 8'h00,
  parameter logic [23:0] BLANK_RGB       = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  input  logic        is_fireboy,
  input  logic        is_icegirl,
  input  logic [7:0]  fireboy_data,
  input  logic [7:0]  icegirl_data,
  input  logic [7:0]  bg_data,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_wdata,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out
);

  logic       r_f1;
  logic       r_i1;
  logic       r_b1;
  logic       r_h1;
  logic       r_v1;
  logic       r_b2;
  logic       r_h2;
  logic       r_v2;
  color_idx_t w_sel_idx;
  rgb_t       w_pal_q;
  rgb_t       w_pix;

  // Stage 1: flags wait one cycle so they meet the registered ROM indices.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_f1 <= 1'b0;
      r_i1 <= 1'b0;
      r_b1 <= 1'b0;
      r_h1 <= 1'b1;
      r_v1 <= 1'b1;
    end else begin
      r_f1 <= is_fireboy;
      r_i1 <= is_icegirl;
      r_b1 <= blank_in;
      r_h1 <= hs_in;
      r_v1 <= vs_in;
    end
  end

  assign w_sel_idx = pick_layer(r_f1, color_idx_t'(fireboy_data), r_i1,
                                color_idx_t'(icegirl_data), color_idx_t'(bg_data),
                                TRANSPARENT_IDX);

  palette_ram u_palette (
    .i_clk   (Clk),
    .i_we    (pal_we),
    .i_waddr (color_idx_t'(pal_addr)),
    .i_wdata (rgb_t'(pal_wdata)),
    .i_raddr (w_sel_idx),
    .o_rdata (w_pal_q)
  );

  // Stage 2: strobes travel alongside the palette read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_b2 <= 1'b0;
      r_h2 <= 1'b1;
      r_v2 <= 1'b1;
    end else begin
      r_b2 <= r_b1;
      r_h2 <= r_h1;
      r_v2 <= r_v1;
    end
  end

  assign w_pix = r_b2 ? w_pal_q : rgb_t'(BLANK_RGB);

  // Stage 3: output register feeding the DAC pins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      blank_out <= 1'b0;
    end else begin
      red       <= w_pix.r;
      green     <= w_pix.g;
      blue      <= w_pix.b;
      hs_out    <= r_h2;
      vs_out    <= r_v2;
      blank_out <= r_b2;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: random and directed pixels checked against a priority/palette model.
module tb_sprite_compositor;

  localparam logic [7:0]  TR = 8'h00;
  localparam logic [23:0] BL = 24'h000000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_in = 1'b0;
  logic        is_fireboy = 1'b0;
  logic        is_icegirl = 1'b0;
  logic [7:0]  fireboy_data = 8'h00;
  logic [7:0]  icegirl_data = 8'h00;
  logic [7:0]  bg_data = 8'h00;
  logic        pal_we = 1'b0;
  logic [7:0]  pal_addr = 8'h00;
  logic [23:0] pal_wdata = 24'h0;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hs_out;
  logic        vs_out;
  logic        blank_out;
  logic [26:0] outv;

  sprite_compositor #(.TRANSPARENT_IDX(TR), .BLANK_RGB(BL)) dut (
    .Clk(Clk), .Reset(Reset), .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .is_fireboy(is_fireboy), .is_icegirl(is_icegirl), .fireboy_data(fireboy_data),
    .icegirl_data(icegirl_data), .bg_data(bg_data), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .red(red), .green(green), .blue(blue), .hs_out(hs_out),
    .vs_out(vs_out), .blank_out(blank_out)
  );

  assign outv = {red, green, blue, hs_out, vs_out, blank_out};

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [26:0] val;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [23:0] mpal [256];
  string       cur_tag = "init";

  // The pixel issued last cycle; its colour indices are driven this cycle.
  logic        p_valid = 1'b0;
  logic        p_f, p_i, p_b, p_h, p_v;
  logic [7:0]  n_fd = 8'h00, n_id = 8'h00, n_bg = 8'h00;

  localparam logic [26:0] RST_OUT = {24'h000000, 1'b1, 1'b1, 1'b0};

  function automatic logic [26:0] expect_px(input logic f, input logic i, input logic b,
                                            input logic h, input logic v, input logic [7:0] fd,
                                            input logic [7:0] id, input logic [7:0] bg);
    logic [7:0]  idx;
    logic [23:0] c;
    if (f && fd != TR)      idx = fd;
    else if (i && id != TR) idx = id;
    else                    idx = bg;
    c = b ? mpal[idx] : BL;
    return {c, h, v, b};
  endfunction

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got rgb=%h hs/vs/blank=%b expected rgb=%h hs/vs/blank=%b",
               name, cyc, act[26:3], act[2:0], exp[26:3], exp[2:0]);
    end
  endtask

  // Issue one pixel; the previous pixel's palette read shares this cycle's write (old data wins).
  task automatic pix(input logic f, input logic i, input logic b, input logic h, input logic v,
                     input logic [7:0] fd, input logic [7:0] id, input logic [7:0] bg,
                     input logic we = 1'b0, input logic [7:0] wa = 8'h00,
                     input logic [23:0] wd = 24'h0);
    exp_t e;
    @(posedge Clk);
    #2;
    is_fireboy = f; is_icegirl = i; blank_in = b; hs_in = h; vs_in = v;
    fireboy_data = n_fd; icegirl_data = n_id; bg_data = n_bg;
    pal_we = we; pal_addr = wa; pal_wdata = wd;
    if (p_valid) begin
      e.due = cyc + 2;
      e.val = expect_px(p_f, p_i, p_b, p_h, p_v, n_fd, n_id, n_bg);
      e.tag = cur_tag;
      q.push_back(e);
    end
    if (we) mpal[wa] = wd;
    p_valid = 1'b1;
    p_f = f; p_i = i; p_b = b; p_h = h; p_v = v;
    n_fd = fd; n_id = id; n_bg = bg;
  endtask

  task automatic rand_pix();
    logic [7:0] fd, id, bg;
    fd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 15));
    id = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 15));
    bg = 8'($urandom_range(0, 15));
    pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
        ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0), fd, id, bg,
        ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 15)), 24'($urandom));
  endtask

  // Called right after pix(); asserts reset mid-cycle and checks the immediate response.
  task automatic assert_reset(input string name);
    #2;
    Reset = 1'b1;
    #1;
    chk(name, outv, RST_OUT);
    q.delete();
    p_valid = 1'b0;
    pal_we = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      #3;
      chk({name, "_hold"}, outv, RST_OUT);
    end
  endtask

  task automatic release_reset(input string name);
    exp_t e;
    pix(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h05);
    #2;
    Reset = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      e.due = cyc + k;
      e.val = RST_OUT;
      e.tag = name;
      q.push_back(e);
    end
  endtask

  // Monitor: compares every output cycle that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation due at cyc %0d never compared", e.tag, e.due);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk(e.tag, outv, e.val);
      end
    end
  end

  initial begin
    logic [23:0] wd;
    #1 Reset = 1'b1;
    #1 chk("reset_init", outv, RST_OUT);
    repeat (2) @(posedge Clk);
    release_reset("reset_release");

    cur_tag = "pal_load";
    for (int a = 0; a < 256; a++) begin
      wd = (a == 5) ? 24'h112233 : (a == 7) ? 24'hFF0000 : (a == 9) ? 24'h0000FF : 24'($urandom);
      pix(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 8'(a), wd);
    end

    cur_tag = "bg_only";      pix(0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h05);
    cur_tag = "fireboy";      pix(1, 0, 1, 1, 1, 8'h07, 8'h00, 8'h05);
    cur_tag = "fireboy_tr";   pix(1, 0, 1, 1, 1, 8'h00, 8'h00, 8'h05);
    cur_tag = "overlap";      pix(1, 1, 1, 1, 1, 8'h07, 8'h09, 8'h05);
    cur_tag = "overlap_tr";   pix(1, 1, 1, 1, 1, 8'h00, 8'h09, 8'h05);
    cur_tag = "flag_blanked"; pix(1, 1, 0, 1, 1, 8'h07, 8'h09, 8'h05);
    cur_tag = "hs_pulse";     pix(0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h05);
    cur_tag = "vs_pulse";     pix(0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h05);
    cur_tag = "blank_pulse";  pix(0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h05);
    cur_tag = "coll_pre";     pix(0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h05);
    cur_tag = "coll_old";     pix(0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h05, 1'b1, 8'h05, 24'hABCDEF);
    cur_tag = "coll_new";     pix(0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h05);
    cur_tag = "coll_after";   pix(0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00);

    cur_tag = "random_a";
    repeat (500) rand_pix();
    assert_reset("reset_mid");
    release_reset("reset_mid_release");
    cur_tag = "random_b";
    repeat (300) rand_pix();

    cur_tag = "drain";
    repeat (4) pix(0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge Clk);
    #3;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
